// File: rtl/timer.sv
// rtl/timer.sv - three-digit BCD M:SS countdown timer for the oven controller
// Optional feature macro TIMER_DIGIT_CHECK_EN: keypad digits above 9 are ignored in load mode.
module timer (
  output logic [3:0] minutes,
  output logic [3:0] tens_secs,
  output logic [3:0] secs,
  output logic       timer_done,
  input  logic [3:0] digit,
  input  logic       clearn,
  input  logic       enable,
  input  logic       loadn,
  input  logic       CLK
);

  logic digit_ok;

`ifdef TIMER_DIGIT_CHECK_EN
  assign digit_ok = (digit <= 4'd9);
`else
  assign digit_ok = 1'b1;
`endif

  assign timer_done = (minutes == 4'd0) && (tens_secs == 4'd0) && (secs == 4'd0);

  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      minutes   <= 4'd0;
      tens_secs <= 4'd0;
      secs      <= 4'd0;
    end else if (!loadn) begin
      // Keypad entry shifts in from the right; the old minutes digit falls off.
      if (digit_ok) begin
        minutes   <= tens_secs;
        tens_secs <= secs;
        secs      <= digit;
      end
    end else if (enable && !timer_done) begin
      if (secs != 4'd0) begin
        secs <= secs - 4'd1;
      end else if (tens_secs != 4'd0) begin
        secs      <= 4'd9;
        tens_secs <= tens_secs - 4'd1;
      end else begin
        // Not done, so minutes must be nonzero here.
        secs      <= 4'd9;
        tens_secs <= 4'd5;
        minutes   <= minutes - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - randomized self-checking bench for timer against a digit-level reference model
module tb_timer;

  logic       CLK = 1'b0;
  logic       clearn;
  logic       enable;
  logic       loadn;
  logic [3:0] digit;
  logic [3:0] minutes, tens_secs, secs;
  logic       timer_done;

  int n_checks = 0;
  int n_fail   = 0;
  int m_m = 0, m_t = 0, m_s = 0;

  timer dut (
    .minutes   (minutes),
    .tens_secs (tens_secs),
    .secs      (secs),
    .timer_done(timer_done),
    .digit     (digit),
    .clearn    (clearn),
    .enable    (enable),
    .loadn     (loadn),
    .CLK       (CLK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit digit_accepted(input int d);
`ifdef TIMER_DIGIT_CHECK_EN
    return d <= 9;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: a display value in seconds-with-borrow terms, digits as plain integers.
  task automatic model_edge(input bit ld_n, input bit en, input int d);
    if (!ld_n) begin
      if (digit_accepted(d)) begin
        m_m = m_t;
        m_t = m_s;
        m_s = d;
      end
    end else if (en) begin
      if (m_s > 0)      m_s = m_s - 1;
      else if (m_t > 0) begin m_s = 9; m_t = m_t - 1; end
      else if (m_m > 0) begin m_s = 9; m_t = 5; m_m = m_m - 1; end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] em, et, es;
    em = 4'(m_m); et = 4'(m_t); es = 4'(m_s);
    check(tag, {4'h0, minutes, tens_secs, secs}, {4'h0, em, et, es});
    check({tag, "_done"}, {15'd0, timer_done}, {15'd0, (m_m == 0 && m_t == 0 && m_s == 0)});
  endtask

  task automatic clk_edge(input bit ld_n, input bit en, input int d);
    loadn  = ld_n;
    enable = en;
    digit  = 4'(d);
    @(posedge CLK);
    model_edge(ld_n, en, d);
    #1;
  endtask

  task automatic pulse_clear(input string tag);
    clearn = 1'b0;
    #1;
    m_m = 0; m_t = 0; m_s = 0;
    check(tag, {4'h0, minutes, tens_secs, secs}, 16'h0000);
    check({tag, "_done"}, {15'd0, timer_done}, 16'd1);
    clearn = 1'b1;
    #1;
  endtask

  initial begin
    logic [15:0] exp6;
    int r;
    clearn = 1'b0; loadn = 1'b1; enable = 1'b0; digit = 4'd0;
    #3;
    check("reset_digits", {4'h0, minutes, tens_secs, secs}, 16'h0000);
    check("reset_done", {15'd0, timer_done}, 16'd1);
    @(negedge CLK);
    clearn = 1'b1;
    @(posedge CLK); #1;

    // 1: asynchronous clear from an arbitrary loaded state
    clk_edge(0, 0, 4); clk_edge(0, 0, 5); clk_edge(0, 0, 6);
    check_model("pre_clear");
    pulse_clear("async_clear");

    // 2: keypad load of 2,1,7,9
    clk_edge(0, 1, 2); clk_edge(0, 1, 1); clk_edge(0, 0, 7); clk_edge(0, 0, 9);
    check("load_179", {4'h0, minutes, tens_secs, secs}, 16'h0179);
    check("load_179_done", {15'd0, timer_done}, 16'd0);

    // 3: count down from 1:79 through the oversized tens digit to 0:00
    for (int i = 1; i <= 142; i++) begin
      clk_edge(1, 1, i % 16);
      if (i == 9)   check("cnt_9",   {4'h0, minutes, tens_secs, secs}, 16'h0170);
      if (i == 79)  check("cnt_79",  {4'h0, minutes, tens_secs, secs}, 16'h0100);
      if (i == 80)  check("cnt_80",  {4'h0, minutes, tens_secs, secs}, 16'h0059);
      if (i == 139) check("cnt_139", {4'h0, minutes, tens_secs, secs, 4'h0} >> 4, 16'h0000);
      if (i == 139) check("cnt_139_done", {15'd0, timer_done}, 16'd1);
      if (i == 142) check("cnt_hold0", {4'h0, minutes, tens_secs, secs}, 16'h0000);
    end
    check_model("cnt_model");

    // 4: hold with enable low, then resume
    clk_edge(0, 0, 0); clk_edge(0, 0, 5); clk_edge(0, 0, 9);
    for (int i = 0; i < 5; i++) clk_edge(1, 0, 3);
    check("hold_059", {4'h0, minutes, tens_secs, secs}, 16'h0059);
    clk_edge(1, 1, 0);
    check("resume_058", {4'h0, minutes, tens_secs, secs}, 16'h0058);

    // 5: clear mid-count; count must not resume
    clk_edge(0, 0, 1); clk_edge(0, 0, 2); clk_edge(0, 0, 4); clk_edge(1, 1, 0);
    check("at_123", {4'h0, minutes, tens_secs, secs}, 16'h0123);
    loadn = 1'b1; enable = 1'b1;
    pulse_clear("mid_clear");
    clk_edge(1, 1, 0); clk_edge(1, 1, 0);
    check("no_resume", {4'h0, minutes, tens_secs, secs}, 16'h0000);

    // 6: out-of-range keypad digit
    clk_edge(0, 0, 3); clk_edge(0, 0, 12);
`ifdef TIMER_DIGIT_CHECK_EN
    exp6 = 16'h0003;
`else
    exp6 = 16'h003c;
`endif
    check("digit_gt9", {4'h0, minutes, tens_secs, secs}, exp6);
    clk_edge(1, 1, 0);
    check_model("big_digit_dec");

    // Randomized operation mix against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_clear("rnd_clear");
      end else if (r < 35) begin
        clk_edge(0, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
        check_model("rnd_load");
      end else begin
        clk_edge(1, ($urandom_range(0, 4) != 0), $urandom_range(0, 15));
        check_model("rnd_run");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
